// File: rtl/beta_mem_responder.sv
// Memory-side responder for the Beta CPU: one word request at a time, programmable wait states.
// Define BETA_MEM_ALIGN_CHECK_EN to reject requests whose byte address is not word aligned.
module beta_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  // ACCESS is the single cycle between the accept edge and either WAIT or RESP,
  // which gives a response WAIT_CYCLES+1 edges after the accept edge.
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] rd_word_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, range_err, align_err, req_bad, enter_resp;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  req_idx;

  assign accept    = req_valid && (state_q == IDLE);
  assign word_addr = req_addr >> 2;
  assign req_idx   = req_addr[IDX_W+1:2];
  assign range_err = (word_addr >= ADDR_W'(DEPTH));
  assign req_bad   = range_err || align_err;

`ifdef BETA_MEM_ALIGN_CHECK_EN
  assign align_err = (req_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign align_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= req_bad;
        idx_q <= req_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:   if (req_valid) state_d = ACCESS;
      ACCESS: begin
        if (WAIT_CYCLES > 0) begin
          state_d = WAIT;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on state and captured registers, never directly on inputs.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? rd_word_q : '0;
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk) begin
    if (reset && accept && req_we && !req_bad) begin
      mem[req_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp) begin
      rd_word_q <= mem[idx_q];
    end
  end

endmodule
